iob_pll_reset_sequencer: RTL and testbench

IOB_PLL_RESET_SEQUENCER -- requirements
Module: iob_pll_reset_sequencer

---
 rtl/iob_pll_reset_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_iob_pll_reset_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/iob_pll_reset_sequencer.sv
// Purpose: pulse the PLL reset, qualify lock, then release per-domain resets in a staggered order.
// Latency: locked_i passes SYNC_STAGES flops; every output is registered one cycle after its decision.
// Backpressure: none; restart_i and arst_n_i override everything, and a lock loss re-enters PLL reset.
module iob_pll_reset_sequencer #(
  parameter int N_OUT              = 3,
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 8,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT       = 1000,
  parameter int STAGGER_CYCLES     = 4,
  parameter int MAX_RETRIES        = 3,
  parameter int CNT_W              = 8
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             locked_i,
  input  logic             restart_i,
  output logic             pll_rst_o,
  output logic [N_OUT-1:0] rst_o,
  output logic             ready_o,
  output logic             fail_o,
  output logic [CNT_W-1:0] lock_loss_cnt_o
);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  // One shared timer: PLL reset length, lock timeout window, or release stagger.
  logic [31:0]            cnt_q, cnt_d;
  logic [31:0]            stable_q, stable_d;
  logic [31:0]            retry_q, retry_d;
  logic [N_OUT-1:0]       rst_q, rst_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   ready_q, ready_d;
  logic                   fail_q, fail_d;
  logic [CNT_W-1:0]       loss_q, loss_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Synchronize the asynchronous lock indication into clk_i.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked_i};
    end
  end

  // Next-state, timers and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    rst_d    = rst_q;
    loss_d   = loss_q;

    case (state_q)
      ST_PLL_RST: begin
        rst_d = '1;
        if (cnt_q == 32'(PLL_RST_CYCLES - 1)) begin
          state_d  = ST_WAIT_LOCK;
          cnt_d    = '0;
          stable_d = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_WAIT_LOCK: begin
        rst_d    = '1;
        cnt_d    = cnt_q + 32'd1;
        stable_d = locked_s ? stable_q + 32'd1 : '0;
        // Qualification is checked first so it wins over a coincident timeout.
        if (locked_s && (stable_q + 32'd1 == 32'(LOCK_STABLE_CYCLES))) begin
          state_d  = ST_RELEASE;
          cnt_d    = '0;
          stable_d = '0;
        end else if (cnt_q == 32'(LOCK_TIMEOUT - 1)) begin
          retry_d  = retry_q + 32'd1;
          cnt_d    = '0;
          stable_d = '0;
          if (retry_q + 32'd1 < 32'(MAX_RETRIES)) begin
            state_d = ST_PLL_RST;
          end else begin
            state_d = ST_FAIL;
          end
        end
      end

      ST_RELEASE: begin
        cnt_d = cnt_q + 32'd1;
        // Released bits are only ever cleared here, so they stay low once dropped.
        for (int i = 0; i < N_OUT; i++) begin
          if (cnt_q + 32'd1 == 32'((i + 1) * STAGGER_CYCLES)) begin
            rst_d[i] = 1'b0;
          end
        end
        if (cnt_q == 32'(N_OUT * STAGGER_CYCLES)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        rst_d = rst_q;
      end

      ST_FAIL: begin
        rst_d = '1;
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
        rst_d   = '1;
      end
    endcase

    // Lock lost after qualification: count it and start over with a fresh retry budget.
    if ((state_q == ST_RELEASE || state_q == ST_RUN) && !locked_s) begin
      state_d  = ST_PLL_RST;
      cnt_d    = '0;
      stable_d = '0;
      retry_d  = '0;
      rst_d    = '1;
      if (loss_q != {CNT_W{1'b1}}) begin
        loss_d = loss_q + 1'b1;
      end
    end

    // Soft restart overrides every other transition but keeps the loss history.
    if (restart_i) begin
      state_d  = ST_PLL_RST;
      cnt_d    = '0;
      stable_d = '0;
      retry_d  = '0;
      rst_d    = '1;
      loss_d   = loss_q;
    end
  end

  // Outputs follow the next state so they change in the same edge as the state.
  assign pll_rst_d = (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
  assign ready_d   = (state_d == ST_RUN);
  assign fail_d    = (state_d == ST_FAIL);

  // State, timer and output registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q   <= ST_PLL_RST;
      cnt_q     <= '0;
      stable_q  <= '0;
      retry_q   <= '0;
      rst_q     <= '1;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
      loss_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      retry_q   <= retry_d;
      rst_q     <= rst_d;
      pll_rst_q <= pll_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst_o       = pll_rst_q;
  assign rst_o           = rst_q;
  assign ready_o         = ready_q;
  assign fail_o          = fail_q;
  assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_iob_pll_reset_sequencer.sv
// Directed bench for the PLL reset sequencer at default parameters.
// Expected values are queued before each step and popped when the DUT response is measured.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_iob_pll_reset_sequencer;

  localparam int N_OUT = 3;
  localparam int CNT_W = 8;
  localparam int S_PLL  = 0;
  localparam int S_RST  = 1;
  localparam int S_RDY  = 2;
  localparam int S_FAIL = 3;
  localparam int S_LOSS = 4;
  localparam int BOUND  = 2000;

  logic             clk;
  logic             arst_n;
  logic             locked;
  logic             restart;
  logic             pll_rst;
  logic [N_OUT-1:0] rst;
  logic             ready;
  logic             fail;
  logic [CNT_W-1:0] loss;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_run  = 0;
  int   n_fail = 0;

  iob_pll_reset_sequencer #(
    .N_OUT(3), .SYNC_STAGES(2), .PLL_RST_CYCLES(8), .LOCK_STABLE_CYCLES(16),
    .LOCK_TIMEOUT(1000), .STAGGER_CYCLES(4), .MAX_RETRIES(3), .CNT_W(8)
  ) dut (
    .clk_i          (clk),
    .arst_n_i       (arst_n),
    .locked_i       (locked),
    .restart_i      (restart),
    .pll_rst_o      (pll_rst),
    .rst_o          (rst),
    .ready_o        (ready),
    .fail_o         (fail),
    .lock_loss_cnt_o(loss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sig(input int sel);
    case (sel)
      S_PLL:   sig = 32'(pll_rst);
      S_RST:   sig = 32'(rst);
      S_RDY:   sig = 32'(ready);
      S_FAIL:  sig = 32'(fail);
      default: sig = 32'(loss);
    endcase
  endfunction

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_run++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // Counts falling edges until the selected output equals val; -1 if the bound expires.
  task automatic wait_for(input int sel, input logic [31:0] val, output int n);
    n = -1;
    for (int k = 1; k <= BOUND; k++) begin
      @(negedge clk);
      if (sig(sel) === val) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  initial begin
    int n;
    int tmo;
    arst_n  = 1'b0;
    locked  = 1'b1;
    restart = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    expect_val("reset_pll_rst", 32'd1); check(sig(S_PLL));
    expect_val("reset_rst",     32'd7); check(sig(S_RST));
    expect_val("reset_ready",   32'd0); check(sig(S_RDY));
    expect_val("reset_fail",    32'd0); check(sig(S_FAIL));
    expect_val("reset_loss",    32'd0); check(sig(S_LOSS));

    // Steady lock: 8-cycle PLL reset, 16 stable cycles, then 4/8/12 stagger, ready one later
    arst_n = 1'b1;
    expect_val("pll_rst_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));
    expect_val("rst0_release", 32'd20);
    wait_for(S_RST, 32'd6, n); check(32'(n));
    expect_val("rst1_release", 32'd4);
    wait_for(S_RST, 32'd4, n); check(32'(n));
    expect_val("rst2_release", 32'd4);
    wait_for(S_RST, 32'd0, n); check(32'(n));
    expect_val("ready_rise", 32'd1);
    wait_for(S_RDY, 32'd1, n); check(32'(n));
    repeat (10) @(negedge clk);
    expect_val("run_rst_held", 32'd0); check(sig(S_RST));
    expect_val("run_ready",    32'd1); check(sig(S_RDY));

    // Soft restart from RUN
    pulse_restart();
    expect_val("restart_pll_rst", 32'd1); check(sig(S_PLL));
    expect_val("restart_rst",     32'd7); check(sig(S_RST));
    expect_val("restart_ready",   32'd0); check(sig(S_RDY));
    expect_val("restart_loss",    32'd0); check(sig(S_LOSS));
    expect_val("restart_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));

    // One-cycle lock glitch 10 cycles into WAIT_LOCK restarts qualification
    repeat (9) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    locked = 1'b1;
    expect_val("glitch_rst0_release", 32'd22);
    wait_for(S_RST, 32'd6, n); check(32'(n));
    expect_val("glitch_ready", 32'd9);
    wait_for(S_RDY, 32'd1, n); check(32'(n));

    // Lock loss in RUN: reacts 3 cycles later
    locked = 1'b0;
    expect_val("loss_latency", 32'd3);
    wait_for(S_RDY, 32'd0, n); check(32'(n));
    expect_val("loss_rst",     32'd7); check(sig(S_RST));
    expect_val("loss_pll_rst", 32'd1); check(sig(S_PLL));
    expect_val("loss_count1",  32'd1); check(sig(S_LOSS));
    locked = 1'b1;
    expect_val("loss_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));

    // Drive the loss counter to saturation
    tmo = 0;
    for (int i = 0; i < 254; i++) begin
      wait_for(S_RDY, 32'd1, n); if (n < 0) tmo++;
      locked = 1'b0;
      wait_for(S_RDY, 32'd0, n); if (n < 0) tmo++;
      locked = 1'b1;
    end
    expect_val("loss_count255", 32'd255); check(sig(S_LOSS));
    wait_for(S_RDY, 32'd1, n); if (n < 0) tmo++;
    locked = 1'b0;
    wait_for(S_RDY, 32'd0, n); if (n < 0) tmo++;
    expect_val("loss_saturate", 32'd255); check(sig(S_LOSS));
    expect_val("loss_loop_timeouts", 32'd0); check(32'(tmo));

    // No lock ever: three attempts then FAIL
    pulse_restart();
    expect_val("restart_keeps_loss", 32'd255); check(sig(S_LOSS));
    expect_val("try1_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));
    expect_val("try1_timeout", 32'd1000);
    wait_for(S_PLL, 32'd1, n); check(32'(n));
    expect_val("try2_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));
    expect_val("try2_timeout", 32'd1000);
    wait_for(S_PLL, 32'd1, n); check(32'(n));
    expect_val("try3_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));
    expect_val("try3_to_fail", 32'd1000);
    wait_for(S_FAIL, 32'd1, n); check(32'(n));
    expect_val("fail_pll_rst", 32'd1); check(sig(S_PLL));
    expect_val("fail_rst",     32'd7); check(sig(S_RST));
    expect_val("fail_ready",   32'd0); check(sig(S_RDY));
    repeat (20) @(negedge clk);
    expect_val("fail_held", 32'd1); check(sig(S_FAIL));
    pulse_restart();
    expect_val("fail_restart_fail",    32'd0); check(sig(S_FAIL));
    expect_val("fail_restart_pll_rst", 32'd1); check(sig(S_PLL));

    // Qualification lands on the timeout cycle and must win
    expect_val("tie_pll_len", 32'd8);
    wait_for(S_PLL, 32'd0, n); check(32'(n));
    repeat (982) @(negedge clk);
    locked = 1'b1;
    expect_val("tie_rst0_release", 32'd22);
    wait_for(S_RST, 32'd6, n); check(32'(n));
    expect_val("tie_fail", 32'd0); check(sig(S_FAIL));

    // Asynchronous reset mid-RELEASE takes effect without a clock edge
    arst_n = 1'b0;
    #1;
    expect_val("arst_rst",     32'd7); check(sig(S_RST));
    expect_val("arst_loss",    32'd0); check(sig(S_LOSS));
    expect_val("arst_pll_rst", 32'd1); check(sig(S_PLL));
    expect_val("arst_ready",   32'd0); check(sig(S_RDY));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
